// File: rtl/gate_vector_sequencer_pkg.sv
// Shared definitions for the gate vector sequencer.
//   state_e    : sequencer FSM state encoding (2-bit)
//   Truth*     : reference truth tables for 2-input gates; bit i is y for input vector i
package gate_vector_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [3:0] TruthAnd = 4'b1000;
  localparam logic [3:0] TruthOr  = 4'b1110;
  localparam logic [3:0] TruthXor = 4'b0110;

  // Counter width for a settle window of the given length; at least one bit.
  function automatic int unsigned settle_cnt_width(input int unsigned hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_settle_timer.sv
// Settle-window counter for the gate vector sequencer.
//   clk_i     : rising-edge clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : synchronous clear to zero (has priority over enable_i)
//   enable_i  : advance the count by one
//   expired_o : count has reached HOLD_CYCLES-1
module settle_timer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = settle_cnt_width(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntLast);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive stimulus/response checker for a small combinational gate.
// Walks vec_out_o through every input combination, holds each for HOLD_CYCLES settle
// cycles, samples y_in_i on the following cycle and compares it to EXPECT[vector].
//   clk_i        : rising-edge clock
//   rst_ni       : asynchronous active-low reset
//   start_i      : run request, accepted only in idle
//   vec_out_o    : gate input vector (bit 0 = a, bit 1 = b)
//   y_in_i       : gate output, same clock domain
//   busy_o       : run in progress (accepted start until done state is left)
//   done_o       : one-cycle end-of-run pulse
//   pass_o       : last completed run had zero mismatches
//   err_count_o  : mismatches in the current or last run
//   first_fail_o : first mismatching vector (valid when err_count_o != 0)
module gate_vector_sequencer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int unsigned          N_IN        = 2,
  parameter int unsigned          HOLD_CYCLES = 4,
  parameter logic [(1<<N_IN)-1:0] EXPECT      = TruthAnd
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic [N_IN-1:0] vec_out_o,
  input  logic            y_in_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_count_o,
  output logic [N_IN-1:0] first_fail_o
);

  localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;
  logic mismatch;

  settle_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_settle_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timer_expired)
  );

  assign mismatch = (y_in_i != EXPECT[vec_q]);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    err_d        = err_q;
    first_d      = first_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          vec_d       = '0;
          err_d       = '0;
          first_d     = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          timer_clear = 1'b1;
          state_d     = StSettle;
        end
      end

      StSettle: begin
        if (timer_expired) begin
          state_d = StCheck;
        end else begin
          timer_enable = 1'b1;
        end
      end

      StCheck: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            first_d = vec_q;
          end
        end
        if (vec_q == VecLast) begin
          // done is raised on entry so it is visible for the whole done-state cycle
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          vec_d       = vec_q + 1'b1;
          timer_clear = 1'b1;
          state_d     = StSettle;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        vec_d   = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out_o    = vec_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign first_fail_o = first_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: two instances (EXPECT = AND and EXPECT = OR) watch the
// same emulated gate, whose truth table is chosen per run. Expected results come from
// the table difference (mismatch count and lowest mismatching vector).
module tb_gate_vector_sequencer;
  import gate_vector_sequencer_pkg::*;

  localparam int unsigned Hold   = 4;
  localparam int unsigned VecLen = Hold + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] gate_tbl;

  logic [1:0] vec_a, vec_o;
  logic       y_a, y_o;
  logic       busy_a, busy_o, done_a, done_o, pass_a, pass_o;
  logic [2:0] err_a, err_o;
  logic [1:0] ff_a, ff_o;

  int checks = 0;
  int errors = 0;

  assign y_a = gate_tbl[vec_a];
  assign y_o = gate_tbl[vec_o];

  gate_vector_sequencer #(
    .N_IN        (2),
    .HOLD_CYCLES (Hold),
    .EXPECT      (TruthAnd)
  ) u_dut_and (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .vec_out_o    (vec_a),
    .y_in_i       (y_a),
    .busy_o       (busy_a),
    .done_o       (done_a),
    .pass_o       (pass_a),
    .err_count_o  (err_a),
    .first_fail_o (ff_a)
  );

  gate_vector_sequencer #(
    .N_IN        (2),
    .HOLD_CYCLES (Hold),
    .EXPECT      (TruthOr)
  ) u_dut_or (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .vec_out_o    (vec_o),
    .y_in_i       (y_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .err_count_o  (err_o),
    .first_fail_o (ff_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mismatch count and first failing vector for a gate table against an expected table.
  function automatic int model_errs(input logic [3:0] tbl, input logic [3:0] exp_tbl);
    return $countones(tbl ^ exp_tbl);
  endfunction

  function automatic int model_first(input logic [3:0] tbl, input logic [3:0] exp_tbl);
    logic [3:0] diff;
    diff = tbl ^ exp_tbl;
    for (int i = 0; i < 4; i++) begin
      if (diff[i]) return i;
    end
    return 0;
  endfunction

  task automatic check_results(input string tag, input logic [3:0] tbl);
    int ea, eo;
    ea = model_errs(tbl, TruthAnd);
    eo = model_errs(tbl, TruthOr);
    check({tag, "_err_and"}, 32'(err_a), 32'(ea));
    check({tag, "_pass_and"}, 32'(pass_a), 32'(ea == 0));
    if (ea != 0) check({tag, "_ff_and"}, 32'(ff_a), 32'(model_first(tbl, TruthAnd)));
    check({tag, "_err_or"}, 32'(err_o), 32'(eo));
    check({tag, "_pass_or"}, 32'(pass_o), 32'(eo == 0));
    if (eo != 0) check({tag, "_ff_or"}, 32'(ff_o), 32'(model_first(tbl, TruthOr)));
  endtask

  // One full run from idle. Timeline is indexed by edges after the accepting edge (k=0).
  task automatic run(input string tag, input logic [3:0] tbl, input bit repulse);
    int  exp_vec;
    logic exp_busy, exp_done;
    gate_tbl = tbl;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k <= 4 * VecLen + 1; k++) begin
      if (k > 0) begin
        start = repulse && (k == 3 || k == 4 * VecLen + 1 || $urandom_range(0, 3) == 0);
        @(posedge clk);
        #1 start = 1'b0;
      end
      if (k < 4 * VecLen)       exp_vec = k / VecLen;
      else if (k == 4 * VecLen) exp_vec = 3;
      else                      exp_vec = 0;
      exp_busy = (k <= 4 * VecLen);
      exp_done = (k == 4 * VecLen);
      check({tag, "_vec"}, 32'(vec_a), 32'(exp_vec));
      check({tag, "_busy"}, 32'(busy_a), 32'(exp_busy));
      check({tag, "_done"}, 32'(done_a), 32'(exp_done));
      check({tag, "_vec_or"}, 32'(vec_o), 32'(exp_vec));
      check({tag, "_done_or"}, 32'(done_o), 32'(exp_done));
    end
    check_results(tag, tbl);
    // Results must hold in idle; a changed gate must not disturb them.
    gate_tbl = 4'($urandom_range(0, 15));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_idle_done"}, 32'(done_a), 32'd0);
    check_results({tag, "_hold"}, tbl);
  endtask

  initial begin
    bit reached;
    rst_n    = 1'b0;
    start    = 1'b0;
    gate_tbl = TruthAnd;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", 32'(vec_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_ff", 32'(ff_a), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("and_gate", TruthAnd, 1'b0);
    run("tie0", 4'b0000, 1'b0);
    run("tie1", 4'b1111, 1'b0);
    run("repulse", TruthAnd, 1'b1);
    run("xor_gate", TruthXor, 1'b1);
    for (int r = 0; r < 12; r++) begin
      run("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Mid-run reset while vector 2 is applied.
    gate_tbl = 4'b0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (vec_a == 2'd2) reached = 1'b1;
    end
    check("abort_reach_vec2", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_vec", 32'(vec_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_err", 32'(err_a), 32'd0);
    check("abort_ff", 32'(ff_a), 32'd0);
    check("abort_pass", 32'(pass_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("post_reset", TruthAnd, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
